// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcodes, state encoding and datapath select encodings shared
//               by the multicycle RV32I control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_TGT = 4'd11,
        S_JALR_JMP = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;
    localparam logic [1:0] c_srca_zero  = 2'b11;

    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_mdr    = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts not-ready cycles of one memory access; flags expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    output logic expired
);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (busy) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            // A ready in the limit cycle clears busy, so completion wins.
            assign expired = busy && (r_count == TMO_W'(MEM_TIMEOUT));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle RV32I control unit with memory handshake and trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter bit ENABLE_JUMPS = 1'b1,
    parameter bit ENABLE_UPPER = 1'b1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int TMO_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] instr_op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);

    import ctrl_pkg::*;

    state_t r_state;
    state_t w_next;
    logic   w_busy;
    logic   w_clr;
    logic   w_expired;
    logic   w_decode_illegal;
    logic   r_illegal;
    logic   r_bus_error;

    assign w_busy = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                    && !mem_ready;
    // Any state change restarts the count for the next access.
    assign w_clr  = (w_next != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .busy    (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_decode_illegal) r_illegal   <= 1'b1;
            if (w_expired)        r_bus_error <= 1'b1;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_decode_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_expired) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (instr_op)
                    c_op_load, c_op_store: w_next = S_MEMADR;
                    c_op_rtype:  w_next = S_EXEC_R;
                    c_op_itype:  w_next = S_EXEC_I;
                    c_op_branch: w_next = S_BRANCH;
                    c_op_jal:    w_next = ENABLE_JUMPS ? S_JAL      : S_TRAP;
                    c_op_jalr:   w_next = ENABLE_JUMPS ? S_JALR_TGT : S_TRAP;
                    c_op_lui:    w_next = ENABLE_UPPER ? S_LUI      : S_TRAP;
                    c_op_auipc:  w_next = ENABLE_UPPER ? S_AUIPC    : S_TRAP;
                    default:     w_next = S_TRAP;
                endcase
                w_decode_illegal = (w_next == S_TRAP);
            end
            S_MEMADR:   w_next = (instr_op == c_op_load) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_expired) w_next = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_expired) w_next = S_TRAP;
            end
            S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_JMP, S_LUI, S_AUIPC: w_next = S_ALUWB;
            S_JALR_TGT: w_next = S_JALR_JMP;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        AdrSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = c_res_aluout;
        ALUSrcA  = c_srca_pc;
        ALUSrcB  = c_srcb_rs2;
        ALUOp    = c_aluop_add;
        RegWrite = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = c_srcb_four;
                    MemToReg = c_res_alu;
                    IRWrite  = mem_ready;
                    PCWrite  = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = c_srca_oldpc;
                    ALUSrcB = c_srcb_imm;
                end
                S_MEMADR, S_JALR_TGT: begin
                    ALUSrcA = c_srca_rs1;
                    ALUSrcB = c_srcb_imm;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    MemToReg = c_res_mdr;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = c_srca_rs1;
                    ALUOp   = c_aluop_funct;
                end
                S_EXEC_I: begin
                    ALUSrcA = c_srca_rs1;
                    ALUSrcB = c_srcb_imm;
                    ALUOp   = c_aluop_funct;
                end
                S_ALUWB:  RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = c_srca_rs1;
                    ALUOp   = c_aluop_sub;
                    PCWrite = zero;
                end
                // Jumps load the target and form the OldPC+4 link together.
                S_JAL, S_JALR_JMP: begin
                    ALUSrcA = c_srca_oldpc;
                    ALUSrcB = c_srcb_four;
                    PCWrite = 1'b1;
                end
                S_LUI: begin
                    ALUSrcA = c_srca_zero;
                    ALUSrcB = c_srcb_imm;
                end
                S_AUIPC: begin
                    ALUSrcA = c_srca_oldpc;
                    ALUSrcB = c_srcb_imm;
                end
                default: ;
            endcase
        end
    end

    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_error;
    assign state_o       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Randomized self-checking bench against an instruction-path model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    import ctrl_pkg::*;

    localparam int TMO = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [6:0] instr_op  = '0;
    logic       zero      = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic       illegal_instr, bus_error;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state_o;
    logic [14:0] ctl;

    logic       d2_pc_write, d2_ir_write, d2_adr_src, d2_mem_read, d2_mem_write, d2_reg_write;
    logic       d2_illegal, d2_bus_error;
    logic [1:0] d2_mem_to_reg, d2_alu_src_a, d2_alu_src_b, d2_alu_op;
    logic [3:0] d2_state;

    int errors = 0;
    int checks = 0;
    state_t path[$];

    logic [6:0] legal_ops [9] = '{c_op_load, c_op_store, c_op_rtype, c_op_itype, c_op_branch,
                                  c_op_jal, c_op_jalr, c_op_lui, c_op_auipc};
    logic [6:0] dis_ops [6] = '{c_op_jal, c_op_jalr, c_op_lui, c_op_auipc, c_op_rtype, c_op_load};

    always #5 clk = ~clk;

    assign ctl = {pc_write, ir_write, adr_src, mem_read, mem_write, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, reg_write};

    multicycle_control_fsm #(
        .ENABLE_JUMPS(1'b1), .ENABLE_UPPER(1'b1), .MEM_TIMEOUT(TMO), .TMO_W(3)
    ) u_dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pc_write), .IRWrite(ir_write), .AdrSrc(adr_src), .MemRead(mem_read),
        .MemWrite(mem_write), .MemToReg(mem_to_reg), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
        .ALUOp(alu_op), .RegWrite(reg_write), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_o(state_o)
    );

    multicycle_control_fsm #(
        .ENABLE_JUMPS(1'b0), .ENABLE_UPPER(1'b0), .MEM_TIMEOUT(16), .TMO_W(5)
    ) u_dut_restricted (
        .clk(clk), .rst(rst), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(d2_pc_write), .IRWrite(d2_ir_write), .AdrSrc(d2_adr_src), .MemRead(d2_mem_read),
        .MemWrite(d2_mem_write), .MemToReg(d2_mem_to_reg), .ALUSrcA(d2_alu_src_a),
        .ALUSrcB(d2_alu_src_b), .ALUOp(d2_alu_op), .RegWrite(d2_reg_write),
        .illegal_instr(d2_illegal), .bus_error(d2_bus_error), .state_o(d2_state)
    );

    // Control word each state must present, taken from the state/output table.
    function automatic logic [14:0] exp_ctl(input state_t s, input logic rdy, input logic z);
        logic pcw, irw, adr, mrd, mwr, rw;
        logic [1:0] m2r, a, b, op;
        {pcw, irw, adr, mrd, mwr, rw} = '0;
        m2r = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
        case (s)
            S_FETCH:    begin mrd = 1'b1; b = 2'b10; m2r = 2'b10; pcw = rdy; irw = rdy; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMRD:    begin mrd = 1'b1; adr = 1'b1; end
            S_MEMWB:    begin m2r = 2'b01; rw = 1'b1; end
            S_MEMWR:    begin mwr = 1'b1; adr = 1'b1; end
            S_EXEC_R:   begin a = 2'b10; op = 2'b10; end
            S_EXEC_I:   begin a = 2'b10; b = 2'b01; op = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BRANCH:   begin a = 2'b10; op = 2'b01; pcw = z; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            S_JALR_TGT: begin a = 2'b10; b = 2'b01; end
            S_JALR_JMP: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            S_LUI:      begin a = 2'b11; b = 2'b01; end
            S_AUIPC:    begin a = 2'b01; b = 2'b01; end
            default: ;
        endcase
        return {pcw, irw, adr, mrd, mwr, m2r, a, b, op, rw};
    endfunction

    task automatic build_path(input logic [6:0] op);
        path.delete();
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            c_op_load:   begin path.push_back(S_MEMADR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
            c_op_store:  begin path.push_back(S_MEMADR); path.push_back(S_MEMWR); end
            c_op_rtype:  begin path.push_back(S_EXEC_R); path.push_back(S_ALUWB); end
            c_op_itype:  begin path.push_back(S_EXEC_I); path.push_back(S_ALUWB); end
            c_op_branch: path.push_back(S_BRANCH);
            c_op_jal:    begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
            c_op_jalr:   begin path.push_back(S_JALR_TGT); path.push_back(S_JALR_JMP); path.push_back(S_ALUWB); end
            c_op_lui:    begin path.push_back(S_LUI); path.push_back(S_ALUWB); end
            c_op_auipc:  begin path.push_back(S_AUIPC); path.push_back(S_ALUWB); end
            default:     path.push_back(S_TRAP);
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Walks one legal instruction; a wait of -1 means random 0..TMO not-ready cycles.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fetch_wait, input int data_wait);
        state_t s;
        bit is_mem;
        int waits;
        build_path(op);
        for (int i = 0; i < path.size(); i++) begin
            s = path[i];
            is_mem = (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
            if (!is_mem)             waits = 0;
            else if (s == S_FETCH)   waits = (fetch_wait < 0) ? int'($urandom_range(0, TMO)) : fetch_wait;
            else                     waits = (data_wait < 0) ? int'($urandom_range(0, TMO)) : data_wait;
            for (int w = 0; w <= waits; w++) begin
                mem_ready = is_mem ? (w == waits) : 1'($urandom_range(0, 1));
                zero      = (s == S_BRANCH) ? z : 1'($urandom_range(0, 1));
                instr_op  = (s == S_FETCH) ? 7'($urandom) : op;
                @(negedge clk);
                checks++;
                if (state_o !== 4'(s)) begin
                    errors++;
                    $display("FAIL state op=%b step=%0d wait=%0d: got %0d want %0d", op, i, w, state_o, s);
                end
                checks++;
                if (ctl !== exp_ctl(s, mem_ready, zero)) begin
                    errors++;
                    $display("FAIL ctl op=%b state=%0d: got %b want %b", op, s, ctl, exp_ctl(s, mem_ready, zero));
                end
                @(posedge clk); #1;
            end
        end
        checks++;
        if (state_o !== 4'(S_FETCH) || illegal_instr !== 1'b0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL end op=%b: got state=%0d ill=%b berr=%b want state=0 ill=0 berr=0",
                     op, state_o, illegal_instr, bus_error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mem_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            instr_op  = 7'($urandom);
            @(negedge clk);
            checks++;
            if (ctl !== 15'd0) begin
                errors++;
                $display("FAIL reset_ctl cycle=%0d: got %b want 0", c, ctl);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        checks++;
        if (state_o !== 4'(S_FETCH) || illegal_instr !== 1'b0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d ill=%b berr=%b want 0/0/0", state_o, illegal_instr, bus_error);
        end
    endtask

    task automatic test_add();
        run_instr(c_op_rtype, 1'b0, 0, 0);
    endtask

    task automatic test_load_wait();
        run_instr(c_op_load, 1'b0, 0, 3);
    endtask

    task automatic test_branch();
        run_instr(c_op_branch, 1'b1, 0, 0);
        run_instr(c_op_branch, 1'b0, 0, 0);
    endtask

    task automatic test_jalr();
        run_instr(c_op_jalr, 1'b0, 0, 0);
        run_instr(c_op_jal, 1'b0, TMO, 0);
    endtask

    task automatic test_random();
        do_reset();
        repeat (40) begin
            run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), -1, -1);
        end
    endtask

    task automatic test_disabled();
        bit trap;
        state_t want;
        for (int k = 0; k < 6; k++) begin
            do_reset();
            mem_ready = 1'b1;
            instr_op  = 7'($urandom);
            @(posedge clk); #1;
            instr_op  = dis_ops[k];
            mem_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (d2_state !== 4'(S_DECODE)) begin
                errors++;
                $display("FAIL dis_decode op=%b: got %0d want %0d", dis_ops[k], d2_state, S_DECODE);
            end
            @(posedge clk); #1;
            trap = (k < 4);
            build_path(dis_ops[k]);
            want = trap ? S_TRAP : path[2];
            checks++;
            if (d2_state !== 4'(want) || d2_illegal !== trap) begin
                errors++;
                $display("FAIL dis_next op=%b: got state=%0d ill=%b want state=%0d ill=%b",
                         dis_ops[k], d2_state, d2_illegal, want, trap);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= TMO; c++) begin
            mem_ready = 1'b0;
            instr_op  = 7'($urandom);
            @(negedge clk);
            checks++;
            if (state_o !== 4'(S_FETCH) || mem_read !== 1'b1 || bus_error !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait cycle=%0d: got state=%0d rd=%b berr=%b want 0/1/0",
                         c, state_o, mem_read, bus_error);
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (state_o !== 4'(S_TRAP) || ctl !== 15'd0 || bus_error !== 1'b1 || illegal_instr !== 1'b0) begin
                errors++;
                $display("FAIL tmo_trap cycle=%0d: got state=%0d ctl=%b berr=%b ill=%b want 15/0/1/0",
                         c, state_o, ctl, bus_error, illegal_instr);
            end
            @(posedge clk); #1;
        end
        do_reset();
        checks++;
        if (state_o !== 4'(S_FETCH) || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_release: got state=%0d berr=%b want 0/0", state_o, bus_error);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        instr_op = 7'b1111111;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            instr_op  = 7'($urandom);
            @(negedge clk);
            checks++;
            if (state_o !== 4'(S_TRAP) || ctl !== 15'd0 || illegal_instr !== 1'b1 || bus_error !== 1'b0) begin
                errors++;
                $display("FAIL illegal cycle=%0d: got state=%0d ctl=%b ill=%b berr=%b want 15/0/1/0",
                         c, state_o, ctl, illegal_instr, bus_error);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        instr_op  = c_op_store;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (state_o !== 4'(S_MEMWR) || mem_write !== 1'b1) begin
                errors++;
                $display("FAIL memwr_hold cycle=%0d: got state=%0d wr=%b want 5/1", c, state_o, mem_write);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || ctl !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid: got wr=%b ctl=%b want 0/0", mem_write, ctl);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (state_o !== 4'(S_FETCH)) begin
            errors++;
            $display("FAIL rst_mid_state: got %0d want 0", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jalr();
        test_random();
        test_disabled();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised multicycle control unit for the RV32I datapath. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles through one shared ALU and one memory port. Compared with the single-cycle decoder it adds:
- JAL, JALR, LUI, AUIPC and I-type ALU instructions;
- a ready handshake toward memory, with a wait-timeout;
- a sticky trap state for illegal opcodes and bus errors.

## Interface
Parameters:
- ENABLE_JUMPS, 1: when 0, JAL/JALR decode as illegal.
- ENABLE_UPPER, 1: when 0, LUI/AUIPC decode as illegal.
- MEM_TIMEOUT, 16: maximum wait cycles per memory access; 0 disables the timeout.
- TMO_W, 5: counter width; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_op  in  7  opcode field of the instruction register (IR).
- zero  in  1  ALU zero flag (beq).
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable, including a taken branch.
- IRWrite  out  1  IR load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemToReg  out  2  result mux: 00 = ALUOut, 01 = memory data register, 10 = direct ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = decode funct3/funct7.
- RegWrite  out  1  register file write enable.
- illegal_instr  out  1  sticky; set on an illegal opcode.
- bus_error  out  1  sticky; set on a memory timeout.
- state_o  out  4  current state, for debug.

## Operation
States and Moore outputs (signals not listed are 0):
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, MemToReg=10, ALUOp=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1.
  - Exit to DECODE on mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01 (precomputes the branch target). Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_TGT
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else, or a disabled class → TRAP, setting illegal_instr.
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next: MEMRD for a load, MEMWR for a store.
- MEMRD: MemRead=1, AdrSrc=1. Held until mem_ready, then MEMWB.
- MEMWB: MemToReg=01, RegWrite=1, then FETCH.
- MEMWR: MemWrite=1, AdrSrc=1. Held until mem_ready, then FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: MemToReg=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, MemToReg=00. PCWrite=zero. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, MemToReg=00, PCWrite=1, then ALUWB (links OldPC+4).
- JALR_TGT: ALUSrcA=10, ALUSrcB=01, then JALR_JMP.
- JALR_JMP: MemToReg=00, PCWrite=1. ALUSrcA=01 and ALUSrcB=10 compute OldPC+4. Then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, then ALUWB.
- TRAP: all enables 0. Absorbing; only rst leaves it.

Memory timeout:
- The wait counter clears on entry to FETCH, MEMRD or MEMWR.
- It increments on each cycle of those states with mem_ready=0.
- When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP and bus_error is set.
- mem_ready=1 in the same cycle as the limit wins: the access completes normally.

## Timing
- While rst=1:
  - state = FETCH, counter = 0, illegal_instr = bus_error = 0.
  - All other outputs are forced to 0 combinationally.
- The first cycle after rst deasserts is FETCH with MemRead=1.
- Zero-wait latency in cycles, including fetch:
  - branch 3;
  - R-type, I-type, store, JAL, LUI, AUIPC 4;
  - load 5;
  - JALR 5.
- Each memory wait cycle adds one cycle.
- Request signals remain stable until the cycle mem_ready is sampled high. A mem_ready seen in a state that does not access memory is ignored.
- rst mid-instruction aborts the instruction; no RegWrite or PCWrite is issued in the reset cycle.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams;
  - the state enumeration (4-bit);
  - encodings for ALUSrcA, ALUSrcB, MemToReg and ALUOp.
- Sub-module mem_wait_timer, parameters MEM_TIMEOUT and TMO_W:
  - inputs clk, rst, clr, busy;
  - output expired.
- Next-state logic and output logic go in separate always blocks.

## Test plan
- Reset release, add (0110011), mem_ready held at 1 → states FETCH, DECODE, EXEC_R, ALUWB, FETCH. RegWrite=1 only in the 4th cycle.
- Load (0000011), mem_ready low for 3 cycles in MEMRD → MemRead and AdrSrc=1 held for 4 cycles. MEMWB follows with MemToReg=01; total 8 cycles.
- beq with zero=1, then again with zero=0 → PCWrite pulses in BRANCH only when zero=1. Both return to FETCH after 3 cycles.
- JALR (1100111) → JALR_TGT, then JALR_JMP (PCWrite=1, MemToReg=00), then ALUWB (RegWrite=1). With ENABLE_JUMPS=0 the same opcode goes DECODE → TRAP and illegal_instr=1.
- MEM_TIMEOUT=4, mem_ready stuck at 0 in FETCH → after 4 wait cycles state=TRAP and bus_error=1. Both hold until rst, which returns the block to FETCH with flags cleared.
- Opcode 1111111 → TRAP with illegal_instr=1 and all enables 0. Asserting rst mid-MEMWR yields MemWrite=0 in that cycle.
